vreg_wb_arbiter: RTL and testbench

Write-back stage directly upstream of the vector register file (16 x 128-bit, two write ports A/B). It accepts result beats from two producers, the vector ALU and the vector load unit, over valid/ready handshakes. Each producer has its own small FIFO. Each cycle the block drives up to two registered writes onto register-file ports A and B. It never writes the same address on both ports in one cycle, and it preserves arrival order for same-address writes.

---
 rtl/vreg_wb_pkg.sv | 21 ++
 rtl/vreg_wb_fifo.sv | 47 ++++
 rtl/vreg_wb_arbiter.sv | 116 +++++++++++
 tb/tb_vreg_wb_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vreg_wb_pkg.sv
// Shared widths and the wrap-aware age compare for the vector write-back arbiter.
// Stamps come from a free-running counter, so age is judged on the modular difference.
package vreg_wb_pkg;

  localparam int VREG_ADDR_W  = 4;
  localparam int VREG_DATA_W  = 128;
  localparam int VREG_FIFO_D  = 2;
  localparam int VREG_STAMP_W = 4;

  // True when stamp_x is older than or the same age as stamp_y.
  function automatic logic older(input logic [31:0] stamp_x,
                                 input logic [31:0] stamp_y,
                                 input int          stamp_w);
    logic [31:0] mask;
    logic [31:0] diff;
    mask = (32'd1 << stamp_w) - 32'd1;
    diff = (stamp_x - stamp_y) & mask;
    return (diff == 32'd0) || (diff >= (32'd1 << (stamp_w - 1)));
  endfunction

endpackage

// File: rtl/vreg_wb_fifo.sv
// Small synchronous FIFO, head visible combinationally; push/pop take effect on the edge.
// The caller must not push when full nor pop when empty.
module vreg_wb_fifo #(
  parameter int W = 8,
  parameter int D = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [W-1:0]         push_dat,
  input  logic                 pop,
  output logic [W-1:0]         head,
  output logic [$clog2(D):0]   count,
  output logic                 full,
  output logic                 empty
);

  localparam int PW = $clog2(D);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [D];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(D));
  assign empty = (count == '0);

endmodule

// File: rtl/vreg_wb_arbiter.sv
// Merges ALU and load result beats onto two registered register-file write ports.
// Beat accepted at edge k issues at edge k+1 at the earliest; ready drops only when a FIFO is full.
module vreg_wb_arbiter
  import vreg_wb_pkg::*;
#(
  parameter int ADDR_W  = VREG_ADDR_W,
  parameter int DATA_W  = VREG_DATA_W,
  parameter int FIFO_D  = VREG_FIFO_D,
  parameter int STAMP_W = VREG_STAMP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              we_a,
  output logic [ADDR_W-1:0] w_addr_a,
  output logic [DATA_W-1:0] data_in_a,
  output logic              we_b,
  output logic [ADDR_W-1:0] w_addr_b,
  output logic [DATA_W-1:0] data_in_b,
  output logic              idle
);

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  data;
    logic [STAMP_W-1:0] stamp;
  } wb_entry_t;

  localparam int EW = $bits(wb_entry_t);
  localparam int CW = $clog2(FIFO_D) + 1;

  logic [STAMP_W-1:0] stamp;
  wb_entry_t          alu_in, ld_in, alu_head, ld_head;
  logic [CW-1:0]      alu_count, ld_count;
  logic               alu_full, alu_empty, ld_full, ld_empty;
  logic               alu_push, ld_push, alu_pop, ld_pop;

  assign alu_ready = !alu_full;
  assign ld_ready  = !ld_full;
  assign alu_push  = alu_valid && alu_ready;
  assign ld_push   = ld_valid && ld_ready;

  assign alu_in = '{addr: alu_addr, data: alu_data, stamp: stamp};
  assign ld_in  = '{addr: ld_addr,  data: ld_data,  stamp: stamp};

  vreg_wb_fifo #(.W(EW), .D(FIFO_D)) u_alu_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (alu_push),
    .push_dat (alu_in),
    .pop      (alu_pop),
    .head     (alu_head),
    .count    (alu_count),
    .full     (alu_full),
    .empty    (alu_empty)
  );

  vreg_wb_fifo #(.W(EW), .D(FIFO_D)) u_ld_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (ld_push),
    .push_dat (ld_in),
    .pop      (ld_pop),
    .head     (ld_head),
    .count    (ld_count),
    .full     (ld_full),
    .empty    (ld_empty)
  );

  // Same-address heads: only the older one goes, keeping per-register write order.
  always_comb begin
    alu_pop = 1'b0;
    ld_pop  = 1'b0;
    if (!alu_empty && !ld_empty && (alu_head.addr == ld_head.addr)) begin
      if (older(32'(alu_head.stamp), 32'(ld_head.stamp), STAMP_W)) alu_pop = 1'b1;
      else                                                         ld_pop  = 1'b1;
    end else begin
      alu_pop = !alu_empty;
      ld_pop  = !ld_empty;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stamp     <= '0;
      we_a      <= 1'b0;
      w_addr_a  <= '0;
      data_in_a <= '0;
      we_b      <= 1'b0;
      w_addr_b  <= '0;
      data_in_b <= '0;
    end else begin
      if (alu_push || ld_push) stamp <= stamp + STAMP_W'(1);
      we_a <= alu_pop;
      we_b <= ld_pop;
      if (alu_pop) begin
        w_addr_a  <= alu_head.addr;
        data_in_a <= alu_head.data;
      end
      if (ld_pop) begin
        w_addr_b  <= ld_head.addr;
        data_in_b <= ld_head.data;
      end
    end
  end

  assign idle = (alu_count == '0) && (ld_count == '0) && !we_a && !we_b;

endmodule

// File: tb/tb_vreg_wb_arbiter.sv
// Bench for vreg_wb_arbiter: vector table, directed corner sequences and random traffic
// checked cycle by cycle against a queue-based model using unbounded arrival numbers.
module tb_vreg_wb_arbiter;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 128;
  localparam int FIFO_D = 2;
  localparam int STAMP_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              alu_valid = 1'b0;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_addr = '0;
  logic [DATA_W-1:0] alu_data = '0;
  logic              ld_valid = 1'b0;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_addr = '0;
  logic [DATA_W-1:0] ld_data = '0;
  logic              we_a, we_b, idle;
  logic [ADDR_W-1:0] w_addr_a, w_addr_b;
  logic [DATA_W-1:0] data_in_a, data_in_b;

  always #5 clk = ~clk;

  vreg_wb_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_D(FIFO_D), .STAMP_W(STAMP_W)
  ) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .we_a(we_a), .w_addr_a(w_addr_a), .data_in_a(data_in_a),
    .we_b(we_b), .w_addr_b(w_addr_b), .data_in_b(data_in_b),
    .idle(idle)
  );

  // Model: each queued beat remembers its global arrival number; lower number = older.
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                seq;
  } beat_t;

  beat_t             qa[$];
  beat_t             ql[$];
  int                seq_n = 0;
  logic              exp_wa, exp_wb;
  logic [ADDR_W-1:0] exp_aa, exp_ba;
  logic [DATA_W-1:0] exp_da, exp_db;
  int                checks = 0;
  int                errors = 0;
  int                dut_acc = 0;
  int                dut_wr = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic model_reset();
    qa.delete();
    ql.delete();
    exp_wa = 1'b0; exp_wb = 1'b0;
    exp_aa = '0;   exp_ba = '0;
    exp_da = '0;   exp_db = '0;
  endtask

  function automatic logic [DATA_W-1:0] alu_pat(input logic [3:0] a);
    return {16{4'hA, a}};
  endfunction

  function automatic logic [DATA_W-1:0] ld_pat(input logic [3:0] a);
    return {16{4'h5, a}};
  endfunction

  // One clock: predict from pre-edge model state, advance, then compare all outputs.
  task automatic step();
    bit    acc_a, acc_l, iss_a, iss_b;
    beat_t ba, bl;
    acc_a = 0; acc_l = 0; iss_a = 0; iss_b = 0;
    if (!rst) begin
      acc_a = alu_valid && (qa.size() < FIFO_D);
      acc_l = ld_valid && (ql.size() < FIFO_D);
      iss_a = qa.size() > 0;
      iss_b = ql.size() > 0;
      if (iss_a && iss_b && qa[0].addr == ql[0].addr) begin
        if (qa[0].seq <= ql[0].seq) iss_b = 0;
        else                        iss_a = 0;
      end
    end
    if (!rst && alu_valid && alu_ready) dut_acc++;
    if (!rst && ld_valid && ld_ready) dut_acc++;
    ba = '{alu_addr, alu_data, seq_n};
    bl = '{ld_addr, ld_data, seq_n};
    @(posedge clk);
    exp_wa = iss_a;
    exp_wb = iss_b;
    if (iss_a) begin exp_aa = qa[0].addr; exp_da = qa[0].data; void'(qa.pop_front()); end
    if (iss_b) begin exp_ba = ql[0].addr; exp_db = ql[0].data; void'(ql.pop_front()); end
    if (acc_a) qa.push_back(ba);
    if (acc_l) ql.push_back(bl);
    if (acc_a || acc_l) seq_n++;
    #1;
    if (we_a) dut_wr++;
    if (we_b) dut_wr++;
    chk("we_a", we_a, exp_wa);
    chk("we_b", we_b, exp_wb);
    chk("w_addr_a", w_addr_a, exp_aa);
    chk("w_addr_b", w_addr_b, exp_ba);
    chk("data_in_a", data_in_a, exp_da);
    chk("data_in_b", data_in_b, exp_db);
    chk("alu_ready", alu_ready, qa.size() < FIFO_D);
    chk("ld_ready", ld_ready, ql.size() < FIFO_D);
    chk("idle", idle, qa.size() == 0 && ql.size() == 0 && !exp_wa && !exp_wb);
    chk("dual_same_addr", we_a && we_b && (w_addr_a == w_addr_b), 1'b0);
  endtask

  typedef struct {
    bit        av; logic [3:0] aa;
    bit        lv; logic [3:0] la;
    bit        e1a; logic [3:0] e1aa;
    bit        e1b; logic [3:0] e1ba;
    bit        e2a;
    bit        e2b; logic [3:0] e2ba;
  } vec_t;

  vec_t vt[6];

  initial begin
    bit fa, fl, seen_low;

    // One accept edge, then the two following output cycles.
    vt[0] = '{1, 3,  0, 0,  1, 3,  0, 0,  0, 0, 0};
    vt[1] = '{0, 0,  1, 4,  0, 0,  1, 4,  0, 0, 0};
    vt[2] = '{1, 5,  1, 9,  1, 5,  1, 9,  0, 0, 0};
    vt[3] = '{1, 2,  1, 2,  1, 2,  0, 0,  0, 1, 2};
    vt[4] = '{1, 15, 1, 0,  1, 15, 1, 0,  0, 0, 0};
    vt[5] = '{1, 0,  1, 0,  1, 0,  0, 0,  0, 1, 0};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we_a", we_a, 1'b0);
    chk("rst_we_b", we_b, 1'b0);
    chk("rst_idle", idle, 1'b1);
    chk("rst_addr_a", w_addr_a, '0);
    chk("rst_data_b", data_in_b, '0);
    rst = 1'b0;
    step();

    foreach (vt[i]) begin
      alu_valid = vt[i].av; alu_addr = vt[i].aa; alu_data = alu_pat(vt[i].aa);
      ld_valid  = vt[i].lv; ld_addr  = vt[i].la; ld_data  = ld_pat(vt[i].la);
      step();
      alu_valid = 1'b0; ld_valid = 1'b0;
      step();
      chk($sformatf("vec%0d_c1_we_a", i), we_a, vt[i].e1a);
      chk($sformatf("vec%0d_c1_we_b", i), we_b, vt[i].e1b);
      if (vt[i].e1a) begin
        chk($sformatf("vec%0d_c1_addr_a", i), w_addr_a, vt[i].e1aa);
        chk($sformatf("vec%0d_c1_data_a", i), data_in_a, alu_pat(vt[i].e1aa));
      end
      if (vt[i].e1b) begin
        chk($sformatf("vec%0d_c1_addr_b", i), w_addr_b, vt[i].e1ba);
        chk($sformatf("vec%0d_c1_data_b", i), data_in_b, ld_pat(vt[i].e1ba));
      end
      step();
      chk($sformatf("vec%0d_c2_we_a", i), we_a, vt[i].e2a);
      chk($sformatf("vec%0d_c2_we_b", i), we_b, vt[i].e2b);
      if (vt[i].e2b) chk($sformatf("vec%0d_c2_addr_b", i), w_addr_b, vt[i].e2ba);
      step();
    end

    // Single beat latency with the 0xAA pattern.
    alu_valid = 1'b1; alu_addr = 4'd3; alu_data = {16{8'hAA}};
    step();
    chk("lat_no_bypass", we_a, 1'b0);
    alu_valid = 1'b0;
    step();
    chk("lat_we_a", we_a, 1'b1);
    chk("lat_addr_a", w_addr_a, 4'd3);
    chk("lat_data_a", data_in_a, {16{8'hAA}});
    chk("lat_we_b", we_b, 1'b0);
    step();
    chk("lat_we_a_drop", we_a, 1'b0);
    chk("lat_addr_hold", w_addr_a, 4'd3);

    // Load r7 one edge before ALU r7.
    ld_valid = 1'b1; ld_addr = 4'd7; ld_data = ld_pat(4'd7);
    step();
    ld_valid = 1'b0;
    alu_valid = 1'b1; alu_addr = 4'd7; alu_data = alu_pat(4'd7);
    step();
    chk("order_ld_first_we_b", we_b, 1'b1);
    chk("order_ld_first_we_a", we_a, 1'b0);
    chk("order_ld_first_addr", w_addr_b, 4'd7);
    alu_valid = 1'b0;
    step();
    chk("order_alu_second_we_a", we_a, 1'b1);
    chk("order_alu_second_we_b", we_b, 1'b0);
    step();

    // Asynchronous reset with beats queued.
    alu_valid = 1'b1; alu_addr = 4'd1; alu_data = alu_pat(4'd1);
    ld_valid  = 1'b1; ld_addr  = 4'd1; ld_data  = ld_pat(4'd1);
    step();
    step();
    alu_valid = 1'b0; ld_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_async_we_a", we_a, 1'b0);
    chk("rst_async_we_b", we_b, 1'b0);
    model_reset();
    step();
    step();
    rst = 1'b0;
    repeat (5) step();
    chk("rst_release_idle", idle, 1'b1);
    chk("rst_release_alu_ready", alu_ready, 1'b1);
    chk("rst_release_ld_ready", ld_ready, 1'b1);

    // Sustained same-address conflict across several stamp wraps.
    dut_acc = 0; dut_wr = 0; seen_low = 0;
    alu_valid = 1'b1; alu_addr = 4'd6; alu_data = {4{$urandom()}};
    ld_valid  = 1'b1; ld_addr  = 4'd6; ld_data  = {4{$urandom()}};
    for (int c = 0; c < 48; c++) begin
      fa = alu_valid && alu_ready;
      fl = ld_valid && ld_ready;
      step();
      if (!ld_ready) seen_low = 1;
      if (fa) alu_data = {4{$urandom()}};
      if (fl) ld_data = {4{$urandom()}};
    end
    alu_valid = 1'b0; ld_valid = 1'b0;
    repeat (8) step();
    chk("bp_ld_ready_low_seen", seen_low, 1'b1);
    chk("bp_beats_conserved", dut_wr, dut_acc);
    chk("bp_idle_after_drain", idle, 1'b1);

    // Random traffic on a narrow address range to provoke conflicts.
    dut_acc = 0; dut_wr = 0;
    for (int c = 0; c < 1500; c++) begin
      fa = alu_valid && alu_ready;
      fl = ld_valid && ld_ready;
      if (!alu_valid || fa) begin
        alu_valid = ($urandom_range(0, 9) < 7);
        alu_addr  = 4'($urandom_range(0, 3));
        alu_data  = {4{$urandom()}};
      end
      if (!ld_valid || fl) begin
        ld_valid = ($urandom_range(0, 9) < 7);
        ld_addr  = 4'($urandom_range(0, 3));
        ld_data  = {4{$urandom()}};
      end
      step();
    end
    alu_valid = 1'b0; ld_valid = 1'b0;
    repeat (8) step();
    chk("rand_beats_conserved", dut_wr, dut_acc);
    chk("rand_idle_after_drain", idle, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
